// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared state type, window decode and parameter legality helpers for mem_io_device
package mem_io_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_e;
  function automatic logic win_hit(input logic cs, input logic iom, input logic is_io,
                                   input logic [31:0] addr, input logic [31:0] base,
                                   input logic [31:0] depth);
    return cs && (iom == is_io) && ((addr & ~(depth - 32'd1)) == base);
  endfunction
  function automatic logic params_ok(input int unsigned depth, input int unsigned base,
                                     input int unsigned ws);
    return depth >= 2 && (depth & (depth - 1)) == 0 && (base & (depth - 1)) == 0 && ws <= 15;
  endfunction
endpackage

// File: rtl/mem_io_ram.sv
// mem_io_ram: single-port DEPTH x DATA_WIDTH storage, synchronous write, read of the addressed word
module mem_io_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_io_device.sv
// mem_io_device: 8088-bus memory/I/O target with window decode, READY wait states,
// strobe-abort and hold-until-release handshaking over an internal byte store.
module mem_io_device
  import mem_io_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter bit          IS_IO       = 1'b0,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CS,
  input  logic                  OE,
  input  logic                  WR,
  input  logic                  IOM,
  input  logic [ADDR_WIDTH-1:0] Address,
  inout  wire  [DATA_WIDTH-1:0] Data,
  output logic                  READY
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  if (!params_ok(DEPTH, BASE_ADDR, WAIT_STATES)) begin : g_bad_params
    $error("mem_io_device: illegal DEPTH/BASE_ADDR/WAIT_STATES");
  end
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW-1:0]         off_q, off_d, ram_addr;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, ram_rdata;
  logic                  hit, rd_req, wr_req, req, released;
  assign hit      = win_hit(CS, IOM, IS_IO, 32'(Address), BASE_ADDR, DEPTH);
  assign rd_req   = hit && !OE && WR;
  assign wr_req   = hit && OE && !WR;
  assign req      = rd_req || wr_req;
  assign released = !CS || (wr_q ? WR : OE);
  // In IDLE the storage is addressed straight from the bus so a zero-wait read can load on entry
  assign ram_addr = (state_q == IDLE) ? Address[AW-1:0] : off_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        off_d   = Address[AW-1:0];
        wr_d    = wr_req;
        cnt_d   = WS;
        state_d = (WS != 4'd0) ? WAIT : ACCESS;
      end
      WAIT: if (released) state_d = IDLE;
            else begin
              cnt_d   = cnt_q - 4'd1;
              state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
            end
      ACCESS: state_d = HOLD;
      HOLD: if (released) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ACCESS && !wr_d) rdata_d = ram_rdata;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end
  mem_io_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk    (CLK),
    .we_i   (state_q == ACCESS && wr_q),
    .addr_i (ram_addr),
    .wdata_i(Data),
    .rdata_o(ram_rdata)
  );
  assign READY = RESET || !(state_q == WAIT || (state_q == IDLE && req && WS != 4'd0));
  assign Data  = ((state_q == ACCESS || state_q == HOLD) && !wr_q) ? rdata_q : 'z;
endmodule
